queue_dispatcher: RTL and testbench
===================================

QUEUE_DISPATCHER -- requirements
Module: queue_dispatcher

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8: queue element width.
REQ-002 SHALL have parameter REGISTER_SIZE, default 32: width of budget, period and statistics registers.
REQ-003 SHALL have port clock  input  1  reset: synchronous, active-high; clock: clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port q_value  input  DATA_SIZE  head element from the queue's BRAM read port; valid FETCH_LATENCY cycles after the head address settles.
REQ-006 SHALL have port q_empty  input  1  queue empty flag.
REQ-007 SHALL have port q_consumed  output  1  one-cycle pulse that advances the queue head.
REQ-008 SHALL have port budget  input  REGISTER_SIZE  elements allowed per window; 0 means unregulated.
REQ-009 SHALL have port period  input  REGISTER_SIZE  window length in cycles; 0 means unregulated.
REQ-010 SHALL have port out_data  output  DATA_SIZE  registered element presented downstream.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts.
REQ-013 SHALL have port throttled  output  1  budget for the current window is exhausted.
REQ-014 SHALL have port served_count  output  REGISTER_SIZE  total handshakes since reset; wraps modulo 2^REGISTER_SIZE.

Function
REQ-015 SHALL implement an FSM with states IDLE, FETCH and VALID.
REQ-016 IDLE -> FETCH when q_empty=0 and throttled=0; otherwise the FSM stays in IDLE.
REQ-017 FETCH SHALL last exactly FETCH_LATENCY=2 cycles (latency counter), then latch q_value into out_data and go to VALID.
REQ-018 In VALID, out_valid=1 and out_data SHALL be held stable until the handshake (out_valid & out_ready).
REQ-019 In the handshake cycle: q_consumed=1 for exactly that cycle, served_count+1, used+1, next state IDLE.
REQ-020 q_consumed SHALL be 0 in every other cycle; at most one pulse per element; never while q_empty=1.
REQ-021 Regulation is enabled iff budget!=0 and period!=0.
REQ-022 Window counter: increments each cycle and wraps to 0 when counter >= period-1.
REQ-023 used resets to 0 at the wrap cycle.
REQ-024 A handshake in the wrap cycle SHALL set used=1, counting toward the new window.
REQ-025 throttled = regulation enabled & (used >= budget).
REQ-026 Regulation is evaluated only in IDLE; an element already in FETCH or VALID completes even if throttled rises.
REQ-027 When regulation is disabled, the window counter and used SHALL hold at 0 and throttled SHALL be 0.
REQ-028 Steady-state throughput with out_ready=1: one element per 4 cycles (IDLE 1, FETCH 2, VALID 1).
REQ-029 out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-030 While reset=1: FSM=IDLE; out_valid=0, out_data=0, q_consumed=0, throttled=0, served_count=0; window counter and used = 0.
REQ-031 Reset in FETCH or VALID SHALL abort the element with no q_consumed pulse; the element stays at the queue head.
REQ-032 The first IDLE evaluation SHALL occur in the first cycle after reset deasserts.

Structure
REQ-033 Package memoredf_pkg SHALL hold the dispatcher state enum and the constant FETCH_LATENCY=2.
REQ-034 The window counter, used counter and throttled logic SHALL be a sub-module budget_regulator (inputs: handshake, budget, period; output: throttled).
REQ-035 The FSM, output register and served_count SHALL live in queue_dispatcher.

Verification
REQ-036 Reset; push 0xA5; out_ready=1 -> out_valid rises 3 cycles after q_empty falls, out_data=0xA5, one q_consumed pulse, served_count=1.
REQ-037 Push 3 elements 0x01,0x02,0x03; out_ready=0 for 10 cycles, then 1 -> 0x01 held stable, no q_consumed while stalled, then in-order output, served_count=3.
REQ-038 budget=2, period=20; push 5; out_ready=1 -> 2 handshakes, then throttled=1 until the wrap at cycle 19, next 2 in the new window, 5th in the third window.
REQ-039 budget=0, period=20; push 8 -> never throttled; 8 handshakes 4 cycles apart.
REQ-040 Assert reset while in VALID with 0x5A -> out_valid=0 next cycle, no q_consumed pulse, served_count=0.
REQ-041 Handshake coincident with the window wrap, budget=1 -> used=1, throttled=1 throughout the new window.

Source files
------------

// File: rtl/memoredf_pkg.sv
// Shared types and constants for the queue dispatcher and its budget regulator.
package memoredf_pkg;

    localparam int FETCH_LATENCY = 2;

    // Last value of the fetch latency counter before the head element is latched.
    localparam logic [1:0] FETCH_LAST = 2'(FETCH_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } disp_state_e;

endpackage

// File: rtl/budget_regulator.sv
// Windowed rate limiter: counts handshakes per period-cycle window and raises
// throttled once the window's budget is used up.
module budget_regulator
    import memoredf_pkg::*;
#(
    parameter int REGISTER_SIZE = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     handshake,
    input  logic [REGISTER_SIZE-1:0] budget,
    input  logic [REGISTER_SIZE-1:0] period,
    output logic                     throttled
);

    localparam logic [REGISTER_SIZE-1:0] ONE = REGISTER_SIZE'(1);

    logic [REGISTER_SIZE-1:0] window_q, window_d;
    logic [REGISTER_SIZE-1:0] used_q, used_d;
    logic                     enabled;
    logic                     wrap;

    assign enabled = (budget != '0) && (period != '0);
    assign wrap    = (window_q >= (period - ONE));

    // A handshake landing on the wrap cycle is charged to the window that starts next.
    always_comb begin
        window_d = '0;
        used_d   = '0;
        if (enabled) begin
            if (wrap) begin
                window_d = '0;
                used_d   = handshake ? ONE : '0;
            end else begin
                window_d = window_q + ONE;
                used_d   = used_q + (handshake ? ONE : '0);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            window_q <= '0;
            used_q   <= '0;
        end else begin
            window_q <= window_d;
            used_q   <= used_d;
        end
    end

    assign throttled = enabled && (used_q >= budget);

endmodule

// File: rtl/queue_dispatcher.sv
// Pulls elements from a BRAM-backed queue head, presents them downstream with a
// valid/ready handshake and rate-limits the pulls through budget_regulator.
module queue_dispatcher
    import memoredf_pkg::*;
#(
    parameter int DATA_SIZE     = 8,
    parameter int REGISTER_SIZE = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DATA_SIZE-1:0]     q_value,
    input  logic                     q_empty,
    output logic                     q_consumed,
    input  logic [REGISTER_SIZE-1:0] budget,
    input  logic [REGISTER_SIZE-1:0] period,
    output logic [DATA_SIZE-1:0]     out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     throttled,
    output logic [REGISTER_SIZE-1:0] served_count
);

    localparam logic [REGISTER_SIZE-1:0] ONE = REGISTER_SIZE'(1);

    disp_state_e              state_q;
    logic [1:0]               lat_q;
    logic [DATA_SIZE-1:0]     out_data_q;
    logic                     out_valid_q;
    logic [REGISTER_SIZE-1:0] served_q;
    logic                     handshake;

    // Reset wins over a coincident handshake so an aborted element stays at the head.
    assign handshake = out_valid_q && out_ready && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            lat_q       <= 2'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            served_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    lat_q <= 2'd0;
                    if (!q_empty && !throttled) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (lat_q == FETCH_LAST) begin
                        out_data_q  <= q_value;
                        out_valid_q <= 1'b1;
                        state_q     <= VALID;
                    end else begin
                        lat_q <= lat_q + 2'd1;
                    end
                end
                VALID: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        served_q    <= served_q + ONE;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    budget_regulator #(
        .REGISTER_SIZE(REGISTER_SIZE)
    ) u_budget_regulator (
        .clock    (clock),
        .reset    (reset),
        .handshake(handshake),
        .budget   (budget),
        .period   (period),
        .throttled(throttled)
    );

    assign q_consumed   = handshake;
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign served_count = served_q;

endmodule

// File: tb/tb_queue_dispatcher.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared each
// cycle against a cycle-number/window-arithmetic model of the dispatcher.
module tb_queue_dispatcher;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  q_value;
    logic        q_empty;
    logic        q_consumed;
    logic [31:0] budget;
    logic [31:0] period;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        throttled;
    logic [31:0] served_count;

    always #5 clock = ~clock;

    queue_dispatcher dut (
        .clock       (clock),
        .reset       (reset),
        .q_value     (q_value),
        .q_empty     (q_empty),
        .q_consumed  (q_consumed),
        .budget      (budget),
        .period      (period),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .throttled   (throttled),
        .served_count(served_count)
    );

    // Queue emulation: memory, pointers and a two-stage read pipeline.
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    logic [7:0] stage1 = 8'd0;
    logic [7:0] stage2 = 8'd0;

    assign q_empty = (wr_ptr == rd_ptr);
    assign q_value = stage2;

    always @(posedge clock) begin
        stage1 <= mem[rd_ptr];
        stage2 <= stage1;
        if (q_consumed) rd_ptr <= rd_ptr + 8'd1;
    end

    // Reference model state.
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc;
    bit         busy;
    int         valid_from;
    int         served;
    int         win_cnt [int];
    logic [7:0] exp_q [$];
    int         hs_cyc [$];
    int         exp_hs_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        else
            n_pass++;
    endtask

    function automatic int wcount(input int w);
        if (win_cnt.exists(w)) return win_cnt[w];
        return 0;
    endfunction

    task automatic model_reset();
        cyc    = 0;
        busy   = 0;
        served = 0;
        win_cnt.delete();
        hs_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_q_consumed", q_consumed, 0);
        chk("rst_throttled", throttled, 0);
        chk("rst_served", served_count, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive inputs, then compare the DUT to the model.
    task automatic step(input bit do_push, input logic [7:0] v, input bit rdy);
        bit en, exp_thr, exp_val, exp_hs;
        @(negedge clock);
        if (do_push) begin
            mem[wr_ptr] = v;
            wr_ptr      = wr_ptr + 8'd1;
            exp_q.push_back(v);
        end
        out_ready = rdy;
        #1;
        en      = (budget != 0) && (period != 0);
        exp_thr = 0;
        if (en) exp_thr = (wcount(cyc / int'(period)) >= int'(budget));
        if (!busy && exp_q.size() > 0 && !exp_thr) begin
            busy       = 1;
            valid_from = cyc + 3;
        end
        exp_val = busy && (cyc >= valid_from);
        exp_hs  = exp_val && rdy;
        chk("out_valid", out_valid, exp_val);
        chk("q_consumed", q_consumed, exp_hs);
        chk("throttled", throttled, exp_thr);
        chk("served_count", served_count, served);
        if (exp_val) chk("out_data", out_data, exp_q[0]);
        if (exp_hs) begin
            $display("handshake cycle=%0d data=%02h served=%0d", cyc, exp_q[0], served + 1);
            void'(exp_q.pop_front());
            served++;
            hs_cyc.push_back(cyc);
            if (en) win_cnt[(cyc + 1) / int'(period)] = wcount((cyc + 1) / int'(period)) + 1;
            busy = 0;
        end
        cyc++;
    endtask

    task automatic check_hs(input string tag);
        chk({tag, "_count"}, hs_cyc.size(), exp_hs_q.size());
        for (int i = 0; i < hs_cyc.size() && i < exp_hs_q.size(); i++)
            chk({tag, "_cycle"}, hs_cyc[i], exp_hs_q[i]);
    endtask

    initial begin
        budget    = 0;
        period    = 0;
        out_ready = 0;

        // Single element, immediate acceptance.
        do_reset();
        step(1, 8'hA5, 1);
        repeat (9) step(0, 8'h00, 1);
        exp_hs_q = '{3};
        check_hs("single");

        // Three elements with a 10-cycle downstream stall.
        do_reset();
        step(1, 8'h01, 0);
        step(1, 8'h02, 0);
        step(1, 8'h03, 0);
        repeat (10) step(0, 8'h00, 0);
        repeat (17) step(0, 8'h00, 1);
        exp_hs_q = '{13, 17, 21};
        check_hs("stall");

        // Budget 2 per 20-cycle window.
        budget = 2;
        period = 20;
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 8'(8'h10 + i), 1);
        repeat (55) step(0, 8'h00, 1);
        exp_hs_q = '{3, 7, 23, 27, 43};
        check_hs("budget2");

        // Regulation disabled by a zero budget.
        budget = 0;
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 8'(8'h20 + i), 1);
        repeat (32) step(0, 8'h00, 1);
        exp_hs_q = '{3, 7, 11, 15, 19, 23, 27, 31};
        check_hs("unregulated");

        // Handshake on the wrap cycle is charged to the new window.
        budget = 1;
        do_reset();
        repeat (16) step(0, 8'h00, 1);
        step(1, 8'hB1, 1);
        step(1, 8'hB2, 1);
        repeat (40) step(0, 8'h00, 1);
        exp_hs_q = '{19, 43};
        check_hs("wrap");

        // Reset while an element is presented: no pulse, element retried later.
        budget = 0;
        do_reset();
        step(1, 8'h5A, 0);
        repeat (4) step(0, 8'h00, 0);
        @(negedge clock);
        reset     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("abort_q_consumed", q_consumed, 0);
        @(negedge clock);
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_served", served_count, 0);
        chk("abort_head_kept", 32'(q_empty), 0);
        do_reset();
        repeat (10) step(0, 8'h00, 1);
        exp_hs_q = '{3};
        check_hs("abort_retry");

        // Randomized traffic across several regulation settings.
        for (int r = 0; r < 4; r++) begin
            budget = 32'($urandom_range(0, 3));
            period = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 25));
            do_reset();
            for (int i = 0; i < 300; i++) begin
                step((exp_q.size() < 12) && ($urandom_range(0, 3) == 0),
                     8'($urandom), ($urandom_range(0, 3) != 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
